fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline, sitting directly upstream of decode. Holds the program counter and issues single-outstanding requests to instruction memory over a req/gnt/rvalid handshake. Drives the IF/ID pipeline register (instruction, PC+4, valid) and applies branch/jump redirects, stalls and flushes from decode and hazard logic.

---
 rtl/fetch_stage.sv | 157 +++++++++++++++
 tb/tb_fetch_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction-fetch stage with a single-outstanding req/gnt/rvalid
// memory port, feeding the IF/ID pipeline register.
`default_nettype none

module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_nrst,
   input  logic        i_con_stall,
   input  logic        i_con_flush,
   input  logic        i_con_ifbranch,
   input  logic        i_con_jump,
   input  logic [31:0] i_addr_pcbranch,
   input  logic [31:0] i_addr_jump,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_gnt,
   input  logic        i_imem_rvalid,
   input  logic [31:0] i_imem_rdata,
   output logic [31:0] o_addr_pc4,
   output logic [31:0] o_data_instr,
   output logic        o_valid,
   output logic [31:0] o_addr_pc
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   state_t      state;
   state_t      state_n;
   logic [31:0] pc;
   logic [31:0] pc_n;
   logic [31:0] pc_plus4;
   logic        kill;
   logic        kill_n;
   logic [31:0] hold_instr;
   logic [31:0] hold_instr_n;
   logic        deliver;
   logic [31:0] deliver_instr;
   logic        redirect;
   logic [31:0] target;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc4;
   logic        ifid_valid;

   assign redirect = (i_con_jump | i_con_ifbranch) & ~i_con_stall;
   assign target   = i_con_jump ? i_addr_jump : i_addr_pcbranch;
   assign pc_plus4 = pc + 32'd4;

   assign o_imem_req   = (state == S_REQ);
   assign o_imem_addr  = pc;
   assign o_addr_pc    = pc;
   assign o_addr_pc4   = ifid_pc4;
   assign o_data_instr = ifid_instr;
   assign o_valid      = ifid_valid;

   always_comb begin
      state_n       = state;
      pc_n          = pc;
      kill_n        = kill;
      hold_instr_n  = hold_instr;
      deliver       = 1'b0;
      deliver_instr = 32'h0;
      case (state)
         S_IDLE: begin
            state_n = S_REQ;
            if (redirect) pc_n = target;
         end
         S_REQ: begin
            // A redirect while the request is in flight moves the PC now and
            // marks the already-granted response as stale.
            if (i_imem_gnt) begin
               state_n = S_WAIT;
               kill_n  = redirect;
            end
            if (redirect) pc_n = target;
         end
         S_WAIT: begin
            if (i_imem_rvalid) begin
               if (kill | redirect) begin
                  kill_n  = 1'b0;
                  state_n = S_REQ;
                  if (redirect) pc_n = target;
               end else if (i_con_stall & ~i_con_flush) begin
                  hold_instr_n = i_imem_rdata;
                  state_n      = S_HOLD;
               end else begin
                  deliver       = 1'b1;
                  deliver_instr = i_imem_rdata;
                  pc_n          = pc_plus4;
                  state_n       = S_REQ;
               end
            end else if (redirect) begin
               kill_n = 1'b1;
               pc_n   = target;
            end
         end
         S_HOLD: begin
            if (!i_con_stall) begin
               state_n      = S_REQ;
               hold_instr_n = 32'h0;
               if (redirect) begin
                  pc_n = target;
               end else if (i_con_flush) begin
                  pc_n = pc_plus4;
               end else begin
                  deliver       = 1'b1;
                  deliver_instr = hold_instr;
                  pc_n          = pc_plus4;
               end
            end
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_nrst) begin
         state      <= S_IDLE;
         pc         <= RESET_PC;
         kill       <= 1'b0;
         hold_instr <= 32'h0;
         ifid_instr <= 32'h0;
         ifid_pc4   <= 32'h0;
         ifid_valid <= 1'b0;
      end else begin
         state      <= state_n;
         pc         <= pc_n;
         kill       <= kill_n;
         hold_instr <= hold_instr_n;
         if (i_con_flush | redirect) begin
            ifid_instr <= 32'h0;
            ifid_pc4   <= 32'h0;
            ifid_valid <= 1'b0;
         end else if (i_con_stall) begin
            ifid_instr <= ifid_instr;
            ifid_pc4   <= ifid_pc4;
            ifid_valid <= ifid_valid;
         end else if (deliver) begin
            ifid_instr <= deliver_instr;
            ifid_pc4   <= pc_plus4;
            ifid_valid <= 1'b1;
         end else begin
            ifid_instr <= 32'h0;
            ifid_pc4   <= 32'h0;
            ifid_valid <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized checks of fetch_stage against a
// transaction-level model and a behavioural instruction memory.
`default_nettype none

module tb_fetch_stage;

   localparam logic [31:0] RPC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        stall = 1'b0, flush = 1'b0, branch = 1'b0, jump = 1'b0;
   logic [31:0] pcbranch = 32'h0, jaddr = 32'h0;
   logic        gnt = 1'b0, rvalid = 1'b0;
   logic [31:0] rdata = 32'h0;
   logic        imem_req, valid;
   logic [31:0] imem_addr, addr_pc4, data_instr, addr_pc;

   fetch_stage #(.RESET_PC(RPC)) dut (
      .i_clk(clk), .i_nrst(nrst),
      .i_con_stall(stall), .i_con_flush(flush),
      .i_con_ifbranch(branch), .i_con_jump(jump),
      .i_addr_pcbranch(pcbranch), .i_addr_jump(jaddr),
      .o_imem_req(imem_req), .o_imem_addr(imem_addr),
      .i_imem_gnt(gnt), .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
      .o_addr_pc4(addr_pc4), .o_data_instr(data_instr),
      .o_valid(valid), .o_addr_pc(addr_pc)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // memory environment
   int          gnt_pct = 100;
   int          lat = 1;
   logic [31:0] mix = 32'h0;
   logic        mem_pend = 1'b0;
   int          mem_cnt = 0;
   logic [31:0] mem_addr = 32'h0;

   // transaction-level model: PC, outstanding/drop flags, buffered word, IF/ID
   logic        m_started = 1'b0, m_out = 1'b0, m_drop = 1'b0, m_buf = 1'b0;
   logic [31:0] m_bufw = 32'h0, m_pc = RPC;
   logic        m_v = 1'b0;
   logic [31:0] m_i = 32'h0, m_p4 = 32'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic model_update();
      logic        red, dlv;
      logic [31:0] tgt, dw, pc_old;
      red    = (jump | branch) & ~stall;
      tgt    = jump ? jaddr : pcbranch;
      dlv    = 1'b0;
      dw     = 32'h0;
      pc_old = m_pc;
      if (!nrst) begin
         m_started = 1'b0; m_out = 1'b0; m_drop = 1'b0; m_buf = 1'b0;
         m_bufw = 32'h0; m_pc = RPC; m_v = 1'b0; m_i = 32'h0; m_p4 = 32'h0;
         return;
      end
      if (!m_started) begin
         m_started = 1'b1;
         if (red) m_pc = tgt;
      end else if (m_buf) begin
         if (!stall) begin
            m_buf = 1'b0;
            if (red) m_pc = tgt;
            else begin
               m_pc = pc_old + 32'd4;
               if (!flush) begin dlv = 1'b1; dw = m_bufw; end
            end
         end
      end else if (m_out) begin
         if (rvalid) begin
            m_out = 1'b0;
            if (m_drop || red) begin
               m_drop = 1'b0;
               if (red) m_pc = tgt;
            end else if (stall && !flush) begin
               m_buf = 1'b1; m_bufw = rdata;
            end else begin
               dlv = 1'b1; dw = rdata; m_pc = pc_old + 32'd4;
            end
         end else if (red) begin
            m_drop = 1'b1; m_pc = tgt;
         end
      end else begin
         if (gnt) begin m_out = 1'b1; m_drop = red; end
         if (red) m_pc = tgt;
      end
      if (flush || red) begin
         m_v = 1'b0; m_i = 32'h0; m_p4 = 32'h0;
      end else if (stall) begin
         m_v = m_v;
      end else if (dlv) begin
         m_v = 1'b1; m_i = dw; m_p4 = pc_old + 32'd4;
      end else begin
         m_v = 1'b0; m_i = 32'h0; m_p4 = 32'h0;
      end
   endtask

   task automatic compare();
      chk("req",   32'(imem_req), 32'(m_started && !m_out && !m_buf));
      chk("addr",  imem_addr, m_pc);
      chk("pc",    addr_pc, m_pc);
      chk("valid", 32'(valid), 32'(m_v));
      chk("instr", data_instr, m_i);
      chk("pc4",   addr_pc4, m_p4);
   endtask

   task automatic step();
      logic [31:0] req_addr;
      rvalid   = mem_pend && (mem_cnt == 0);
      rdata    = rvalid ? (mem_addr ^ mix) : 32'h0;
      gnt      = (imem_req === 1'b1) && !mem_pend && ($urandom_range(0, 99) < gnt_pct);
      req_addr = imem_addr;
      @(posedge clk);
      model_update();
      if (rvalid) mem_pend = 1'b0;
      else if (mem_pend) mem_cnt--;
      if (gnt) begin
         mem_pend = 1'b1; mem_cnt = lat - 1; mem_addr = req_addr;
      end
      @(negedge clk);
      compare();
   endtask

   task automatic wait_req(input string name, input logic [31:0] exp, input int max);
      int n = 0;
      while (imem_req !== 1'b1 && n < max) begin step(); n++; end
      if (imem_req !== 1'b1) begin
         checks++; errors++;
         $display("FAIL %s timeout actual=no_req expected=req@%h", name, exp);
      end else chk(name, imem_addr, exp);
   endtask

   task automatic wait_valid(input string name, input logic [31:0] ei, input logic [31:0] ep, input int max);
      int n = 0;
      do begin step(); n++; end while (valid !== 1'b1 && n < max);
      if (valid !== 1'b1) begin
         checks++; errors++;
         $display("FAIL %s timeout actual=no_valid expected=instr %h", name, ei);
      end else begin
         chk({name, "_instr"}, data_instr, ei);
         chk({name, "_pc4"}, addr_pc4, ep);
      end
   endtask

   initial begin
      // reset and steady single-cycle memory
      nrst = 1'b0;
      step(); step();
      chk("rst_valid", 32'(valid), 32'h0);
      chk("rst_instr", data_instr, 32'h0);
      chk("rst_pc4", addr_pc4, 32'h0);
      chk("rst_req", 32'(imem_req), 32'h0);
      chk("rst_addr", imem_addr, 32'h100);
      nrst = 1'b1;
      wait_req("first_req", 32'h100, 4);
      wait_valid("first", 32'h100, 32'h104, 6);
      wait_req("second_req", 32'h104, 4);

      // stall across the response
      stall = 1'b1;
      repeat (4) step();
      chk("stall_noreq", 32'(imem_req), 32'h0);
      chk("stall_hold", data_instr, 32'h100);
      stall = 1'b0;
      wait_valid("stall_rel", 32'h104, 32'h108, 4);
      wait_req("stall_next", 32'h108, 4);

      // jump (with simultaneous branch) over a slow response
      lat = 3;
      step();
      jump = 1'b1; jaddr = 32'h2000; branch = 1'b1; pcbranch = 32'h3000;
      step();
      jump = 1'b0; branch = 1'b0;
      wait_req("jump_tgt", 32'h2000, 8);
      chk("jump_bubble", 32'(valid), 32'h0);
      lat = 1;

      // flush under stall, then branch ignored under stall
      stall = 1'b1; flush = 1'b1;
      step();
      chk("flush_valid", 32'(valid), 32'h0);
      chk("flush_instr", data_instr, 32'h0);
      flush = 1'b0; branch = 1'b1; pcbranch = 32'h5000;
      step();
      chk("stall_branch_pc", addr_pc, 32'h2000);
      branch = 1'b0; stall = 1'b0;
      wait_valid("after_hold", 32'h2000, 32'h2004, 4);

      // PC wrap-around
      jump = 1'b1; jaddr = 32'hFFFF_FFFC;
      step();
      jump = 1'b0;
      wait_valid("wrap", 32'hFFFF_FFFC, 32'h0, 10);
      wait_req("wrap_next", 32'h0, 4);

      // reset while a response is outstanding
      lat = 2;
      step();
      nrst = 1'b0;
      step();
      chk("midrst_addr", imem_addr, 32'h100);
      nrst = 1'b1; lat = 1;
      step();
      wait_req("rst_first", 32'h100, 4);
      chk("rst_novalid", 32'(valid), 32'h0);
      wait_valid("rst_data", 32'h100, 32'h104, 6);

      // randomized traffic
      gnt_pct = 70; mix = 32'hA5A5_0000;
      for (int c = 0; c < 3000; c++) begin
         nrst     = ($urandom_range(0, 199) != 0);
         stall    = ($urandom_range(0, 99) < 20);
         flush    = ($urandom_range(0, 99) < 10);
         branch   = ($urandom_range(0, 99) < 10);
         jump     = ($urandom_range(0, 99) < 5);
         pcbranch = $urandom() & 32'hFFFF_FFFC;
         jaddr    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
         lat      = $urandom_range(1, 3);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
